// File: rtl/pc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pc_seq_ctrl
// Fetch/branch sequencer for a 16-bit program counter. Walks a
// FETCH -> DECODE -> UPDATE loop and issues exactly one PC update per
// instruction. A watchdog aborts a fetch whose acknowledge never arrives.
//
// Optional feature macro: PC_SEQ_CTRL_STATS_EN
//   When defined, adds retired/branch instruction counters.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   begin/resume sequencing from IDLE (ignored while busy)
//   halt        in   stop after the current instruction completes
//   imem_ack    in   instruction word returned (used only in FETCH)
//   dec_valid   in   decoder result valid (used only in DECODE)
//   dec_taken   in   instruction is a taken branch
//   dec_offset  in   signed branch displacement
//   imem_req    out  fetch request, high throughout FETCH
//   inc/add/sub out  one-cycle PC update pulses, mutually exclusive
//   offset      out  unsigned magnitude for the PC, held outside UPDATE
//   busy        out  high in every state except IDLE
//   fault       out  sticky acknowledge-timeout flag
//   retired_cnt out  (stats) UPDATE cycles, wrapping
//   branch_cnt  out  (stats) UPDATE cycles issuing add or sub, wrapping
// ---------------------------------------------------------------------------
module pc_seq_ctrl #(
  parameter int          WIDTH       = 16,
  parameter int unsigned INC_STEP    = 1,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             imem_ack,
  input  logic             dec_valid,
  input  logic             dec_taken,
  input  logic [WIDTH-1:0] dec_offset,
  output logic             imem_req,
  output logic             inc,
  output logic             add,
  output logic             sub,
  output logic [WIDTH-1:0] offset,
  output logic             busy,
  output logic             fault
`ifdef PC_SEQ_CTRL_STATS_EN
  ,
  output logic [15:0]      retired_cnt,
  output logic [15:0]      branch_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  localparam logic [7:0]       WDOG_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W    = '0;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wdog;
  logic [7:0]       w_wdog_n;
  logic             r_halt_pend;
  logic             w_halt_pend_n;
  logic             r_fault;
  logic             w_fault_n;
  logic             r_inc;
  logic             r_add;
  logic             r_sub;
  logic             w_inc_n;
  logic             w_add_n;
  logic             w_sub_n;
  logic [WIDTH-1:0] r_offset;
  logic [WIDTH-1:0] w_offset_n;
  logic             r_imem_req;
  logic             r_busy;

  // Next-state, watchdog, halt tracking and latched PC operation.
  always_comb begin
    w_next        = r_state;
    w_wdog_n      = r_wdog;
    w_halt_pend_n = r_halt_pend;
    w_fault_n     = r_fault;
    w_inc_n       = 1'b0;
    w_add_n       = 1'b0;
    w_sub_n       = 1'b0;
    w_offset_n    = r_offset;
    case (r_state)
      ST_IDLE: begin
        w_halt_pend_n = 1'b0;
        w_wdog_n      = 8'd0;
        if (start) begin
          w_next    = ST_FETCH;
          w_fault_n = 1'b0;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        w_halt_pend_n = r_halt_pend | halt;
        // An ack in the final watchdog cycle still wins over the timeout.
        if (imem_ack) begin
          w_next   = ST_DECODE;
          w_wdog_n = 8'd0;
        end else if (r_wdog == WDOG_LAST) begin
          w_next        = ST_IDLE;
          w_fault_n     = 1'b1;
          w_wdog_n      = 8'd0;
          w_halt_pend_n = 1'b0;
        end else begin
          w_wdog_n = r_wdog + 8'd1;
        end
      end
      ST_DECODE: begin
        w_halt_pend_n = r_halt_pend | halt;
        if (dec_valid) begin
          w_next = ST_UPDATE;
          if (!dec_taken) begin
            w_inc_n    = 1'b1;
            w_offset_n = WIDTH'(INC_STEP);
          end else if (dec_offset == ZERO_W) begin
            w_offset_n = ZERO_W;
          end else if (dec_offset[WIDTH-1]) begin
            // Two's-complement negate; the most-negative value maps onto itself.
            w_sub_n    = 1'b1;
            w_offset_n = ~dec_offset + ONE_W;
          end else begin
            w_add_n    = 1'b1;
            w_offset_n = dec_offset;
          end
        end else begin
          w_next = ST_DECODE;
        end
      end
      ST_UPDATE: begin
        // A halt seen in this final cycle also counts.
        if (r_halt_pend | halt) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_FETCH;
        end
        w_halt_pend_n = 1'b0;
      end
      default: begin
        w_next        = ST_IDLE;
        w_wdog_n      = 8'd0;
        w_halt_pend_n = 1'b0;
      end
    endcase
  end

  // State, control and registered-output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_wdog      <= 8'd0;
      r_halt_pend <= 1'b0;
      r_fault     <= 1'b0;
      r_inc       <= 1'b0;
      r_add       <= 1'b0;
      r_sub       <= 1'b0;
      r_offset    <= ZERO_W;
      r_imem_req  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_wdog      <= w_wdog_n;
      r_halt_pend <= w_halt_pend_n;
      r_fault     <= w_fault_n;
      r_inc       <= w_inc_n;
      r_add       <= w_add_n;
      r_sub       <= w_sub_n;
      r_offset    <= w_offset_n;
      r_imem_req  <= (w_next == ST_FETCH);
      r_busy      <= (w_next != ST_IDLE);
    end
  end

  assign imem_req = r_imem_req;
  assign inc      = r_inc;
  assign add      = r_add;
  assign sub      = r_sub;
  assign offset   = r_offset;
  assign busy     = r_busy;
  assign fault    = r_fault;

`ifdef PC_SEQ_CTRL_STATS_EN
  logic [15:0] r_retired_cnt;
  logic [15:0] r_branch_cnt;

  // Counters step together with the UPDATE cycle they record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired_cnt <= 16'd0;
      r_branch_cnt  <= 16'd0;
    end else if (w_next == ST_UPDATE) begin
      r_retired_cnt <= r_retired_cnt + 16'd1;
      r_branch_cnt  <= r_branch_cnt + {15'd0, (w_add_n | w_sub_n)};
    end else begin
      r_retired_cnt <= r_retired_cnt;
      r_branch_cnt  <= r_branch_cnt;
    end
  end

  assign retired_cnt = r_retired_cnt;
  assign branch_cnt  = r_branch_cnt;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_seq_ctrl
// Directed bench for pc_seq_ctrl. Inputs change 1 ns after the rising edge
// and outputs are compared at the same point, i.e. after each edge settles.
// Output vector order: {imem_req, busy, inc, add, sub, fault}.
// ---------------------------------------------------------------------------
module tb_pc_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt;
  logic        imem_ack;
  logic        dec_valid;
  logic        dec_taken;
  logic [15:0] dec_offset;
  logic        imem_req;
  logic        inc;
  logic        add;
  logic        sub;
  logic [15:0] offset;
  logic        busy;
  logic        fault;
`ifdef PC_SEQ_CTRL_STATS_EN
  logic [15:0] retired_cnt;
  logic [15:0] branch_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [5:0] O_IDLE   = 6'b000000;
  localparam logic [5:0] O_FAULT  = 6'b000001;
  localparam logic [5:0] O_FETCH  = 6'b110000;
  localparam logic [5:0] O_DECODE = 6'b010000;
  localparam logic [5:0] O_INC    = 6'b011000;
  localparam logic [5:0] O_ADD    = 6'b010100;
  localparam logic [5:0] O_SUB    = 6'b010010;
  localparam logic [5:0] O_NOP    = 6'b010000;

  pc_seq_ctrl #(.WIDTH(16), .INC_STEP(1), .ACK_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt       (halt),
    .imem_ack   (imem_ack),
    .dec_valid  (dec_valid),
    .dec_taken  (dec_taken),
    .dec_offset (dec_offset),
    .imem_req   (imem_req),
    .inc        (inc),
    .add        (add),
    .sub        (sub),
    .offset     (offset),
    .busy       (busy),
    .fault      (fault)
`ifdef PC_SEQ_CTRL_STATS_EN
    ,
    .retired_cnt(retired_cnt),
    .branch_cnt (branch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {imem_req, busy, inc, add, sub, fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starting from an observed FETCH cycle with ack/dec_valid high.
  task automatic run_instr(input string tag, input logic taken, input logic [15:0] doff,
                           input logic [5:0] upd_o, input logic [15:0] upd_off,
                           input logic [5:0] after_o);
    dec_taken  = taken;
    dec_offset = doff;
    tick();
    halt = 1'b0;
    chk({tag, "_dec"}, outs(), O_DECODE);
    tick();
    chk({tag, "_upd"}, outs(), upd_o);
    chk({tag, "_off"}, offset, upd_off);
    tick();
    chk({tag, "_after"}, outs(), after_o);
    chk({tag, "_hold"}, offset, upd_off);
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b1;
    halt       = 1'b0;
    imem_ack   = 1'b1;
    dec_valid  = 1'b1;
    dec_taken  = 1'b0;
    dec_offset = 16'h0000;

    // Reset held with start high: everything stays zero.
    tick();
    tick();
    chk("rst_outs", outs(), O_IDLE);
    chk("rst_off", offset, 32'h0);

    // Release; first edge enters FETCH.
    reset = 1'b1;
    tick();
    start = 1'b0;
    chk("loop_fetch", outs(), O_FETCH);
    run_instr("inc1", 1'b0, 16'h0000, O_INC, 16'h0001, O_FETCH);
    run_instr("inc2", 1'b0, 16'h1234, O_INC, 16'h0001, O_FETCH);

    // Branches.
    run_instr("fwd", 1'b1, 16'h0010, O_ADD, 16'h0010, O_FETCH);
    run_instr("bwd", 1'b1, 16'hFFF0, O_SUB, 16'h0010, O_FETCH);
    run_instr("neg_max", 1'b1, 16'h8000, O_SUB, 16'h8000, O_FETCH);
    run_instr("zero", 1'b1, 16'h0000, O_NOP, 16'h0000, O_FETCH);

    // Halt pulsed during FETCH: instruction completes, then IDLE.
    halt = 1'b1;
    run_instr("halt", 1'b0, 16'h0000, O_INC, 16'h0001, O_IDLE);
    halt = 1'b1;
    tick();
    chk("halt_idle", outs(), O_IDLE);
    halt = 1'b0;

    // Timeout: ack withheld for 15 FETCH cycles.
    imem_ack = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("to_fetch15", outs(), O_FETCH);
    tick();
    chk("to_fault", outs(), O_FAULT);
    chk("to_off", offset, 32'h0001);
    tick();
    chk("to_sticky", outs(), O_FAULT);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_clear", outs(), O_FETCH);

    // Ack on exactly the 15th FETCH cycle.
    for (int i = 0; i < 14; i++) tick();
    chk("ack15_fetch", outs(), O_FETCH);
    imem_ack  = 1'b1;
    dec_taken = 1'b0;
    tick();
    chk("ack15_dec", outs(), O_DECODE);
    tick();
    chk("ack15_upd", outs(), O_INC);

    // Reset during DECODE.
    tick();
    chk("rd_fetch", outs(), O_FETCH);
    dec_valid = 1'b0;
    tick();
    tick();
    chk("rd_wait", outs(), O_DECODE);
    reset = 1'b0;
    #1;
    chk("rd_outs", outs(), O_IDLE);
    chk("rd_off", offset, 32'h0);
    dec_valid = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("rd_after", outs(), O_IDLE);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rd_restart", outs(), O_FETCH);

`ifdef PC_SEQ_CTRL_STATS_EN
    run_instr("st1", 1'b1, 16'h0010, O_ADD, 16'h0010, O_FETCH);
    run_instr("st2", 1'b0, 16'h0000, O_INC, 16'h0001, O_FETCH);
    run_instr("st3", 1'b1, 16'hFFF0, O_SUB, 16'h0010, O_FETCH);
    run_instr("st4", 1'b0, 16'h0000, O_INC, 16'h0001, O_FETCH);
    chk("st_retired", retired_cnt, 32'd4);
    chk("st_branch", branch_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
